// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode-stage operands, hazard inputs and pipeline control outputs of the hazard controller
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       D_rs1_index;
    logic [4:0]       D_rs2_index;
    logic             D_rs1_used;
    logic             D_rs2_used;
    logic [4:0]       D_rd_index;
    logic             D_reg_we;
    logic             D_is_load;
    logic             E_jb;
    logic             mem_busy;
    logic             stall_F;
    logic             stall_D;
    logic             flush_D;
    logic             bubble_E;
    logic             freeze;
    logic [1:0]       E_rs1_fwd_sel;
    logic [1:0]       E_rs2_fwd_sel;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] freeze_cnt;

    modport slave (
        input  D_rs1_index, D_rs2_index, D_rs1_used, D_rs2_used,
               D_rd_index, D_reg_we, D_is_load, E_jb, mem_busy,
        output stall_F, stall_D, flush_D, bubble_E, freeze,
               E_rs1_fwd_sel, E_rs2_fwd_sel, stall_cnt, flush_cnt, freeze_cnt
    );

    modport master (
        output D_rs1_index, D_rs2_index, D_rs1_used, D_rs2_used,
               D_rd_index, D_reg_we, D_is_load, E_jb, mem_busy,
        input  stall_F, stall_D, flush_D, bubble_E, freeze,
               E_rs1_fwd_sel, E_rs2_fwd_sel, stall_cnt, flush_cnt, freeze_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, jump/branch flush, memory freeze and E-stage forwarding for a 5-stage RV32I pipe
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input logic       clk,
    input logic       rst,
    hazard_ctrl_if.slave bus
);
    typedef enum logic {RUN, FRZ} state_t;

    state_t           state_q, state_d;
    logic [4:0]       e_rs1_q, e_rs1_d, e_rs2_q, e_rs2_d, e_rd_q, e_rd_d;
    logic             e_we_q, e_we_d, e_load_q, e_load_d;
    logic [4:0]       m_rd_q, m_rd_d, w_rd_q, w_rd_d;
    logic             m_we_q, m_we_d, m_load_q, m_load_d, w_we_q, w_we_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d, freeze_cnt_q, freeze_cnt_d;
    logic             frz, jb, lu_haz, lu, bubble;
    logic [1:0]       fwd1, fwd2;

    // Freeze FSM next state plus prioritised hazard decisions (freeze > jb > load-use)
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     state_d = bus.mem_busy ? FRZ : RUN;
            FRZ:     state_d = bus.mem_busy ? FRZ : RUN;
            default: state_d = RUN;
        endcase
        frz    = state_d == FRZ;
        lu_haz = e_load_q && e_we_q && e_rd_q != 5'd0 &&
                 ((bus.D_rs1_used && bus.D_rs1_index == e_rd_q) ||
                  (bus.D_rs2_used && bus.D_rs2_index == e_rd_q));
        jb     = !frz && bus.E_jb;
        lu     = !frz && !jb && lu_haz;
        bubble = jb || lu;
    end

    // Forwarding selects for E operands; a load in M has no result yet, so only W can supply it
    always_comb begin
        fwd1 = (m_we_q && m_rd_q != 5'd0 && m_rd_q == e_rs1_q && !m_load_q) ? 2'b01 :
               (w_we_q && w_rd_q != 5'd0 && w_rd_q == e_rs1_q) ? 2'b10 : 2'b00;
        fwd2 = (m_we_q && m_rd_q != 5'd0 && m_rd_q == e_rs2_q && !m_load_q) ? 2'b01 :
               (w_we_q && w_rd_q != 5'd0 && w_rd_q == e_rs2_q) ? 2'b10 : 2'b00;
    end

    // Drive outputs; reset forces every output low, counters included
    always_comb begin
        bus.freeze        = !rst && frz;
        bus.stall_F       = !rst && (frz || lu);
        bus.stall_D       = !rst && (frz || lu);
        bus.flush_D       = !rst && jb;
        bus.bubble_E      = !rst && bubble;
        bus.E_rs1_fwd_sel = rst ? 2'b00 : fwd1;
        bus.E_rs2_fwd_sel = rst ? 2'b00 : fwd2;
        bus.stall_cnt     = rst ? '0 : stall_cnt_q;
        bus.flush_cnt     = rst ? '0 : flush_cnt_q;
        bus.freeze_cnt    = rst ? '0 : freeze_cnt_q;
    end

    // Scoreboard advance D->E->M->W unless frozen; x0 is never recorded as a writer
    always_comb begin
        e_rs1_d  = e_rs1_q;
        e_rs2_d  = e_rs2_q;
        e_rd_d   = e_rd_q;
        e_we_d   = e_we_q;
        e_load_d = e_load_q;
        m_rd_d   = m_rd_q;
        m_we_d   = m_we_q;
        m_load_d = m_load_q;
        w_rd_d   = w_rd_q;
        w_we_d   = w_we_q;
        if (!frz) begin
            e_rs1_d  = bubble ? 5'd0 : bus.D_rs1_index;
            e_rs2_d  = bubble ? 5'd0 : bus.D_rs2_index;
            e_rd_d   = bubble ? 5'd0 : bus.D_rd_index;
            e_we_d   = !bubble && bus.D_reg_we && bus.D_rd_index != 5'd0;
            e_load_d = !bubble && bus.D_is_load;
            m_rd_d   = e_rd_q;
            m_we_d   = e_we_q;
            m_load_d = e_load_q;
            w_rd_d   = m_rd_q;
            w_we_d   = m_we_q;
        end
    end

    // Saturating event counters
    always_comb begin
        stall_cnt_d  = (lu && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d  = (jb && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
        freeze_cnt_d = (frz && freeze_cnt_q != '1) ? freeze_cnt_q + CNT_W'(1) : freeze_cnt_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            e_rs1_q      <= '0;
            e_rs2_q      <= '0;
            e_rd_q       <= '0;
            e_we_q       <= 1'b0;
            e_load_q     <= 1'b0;
            m_rd_q       <= '0;
            m_we_q       <= 1'b0;
            m_load_q     <= 1'b0;
            w_rd_q       <= '0;
            w_we_q       <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            e_rs1_q      <= e_rs1_d;
            e_rs2_q      <= e_rs2_d;
            e_rd_q       <= e_rd_d;
            e_we_q       <= e_we_d;
            e_load_q     <= e_load_d;
            m_rd_q       <= m_rd_d;
            m_we_q       <= m_we_d;
            m_load_q     <= m_load_d;
            w_rd_q       <= w_rd_d;
            w_we_q       <= w_we_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of stall, flush, freeze, forwarding, saturation and reset
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    logic [4:0] ctrl;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(4)) bus ();
    hazard_ctrl #(.CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    assign ctrl = {bus.stall_F, bus.stall_D, bus.flush_D, bus.bubble_E, bus.freeze};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic [4:0] rd, input logic we, input logic ld);
        bus.D_rs1_index = rs1;
        bus.D_rs2_index = rs2;
        bus.D_rs1_used  = u1;
        bus.D_rs2_used  = u2;
        bus.D_rd_index  = rd;
        bus.D_reg_we    = we;
        bus.D_is_load   = ld;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.E_jb = 1'b0;
        bus.mem_busy = 1'b0;
        set_d(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.E_jb = 1'b1;
        bus.mem_busy = 1'b1;
        set_d(5, 5, 1, 1, 5, 1, 1);
        total++; if (ctrl !== 5'b00000) begin bad++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, 5'b00000); end
        total++; if (bus.E_rs1_fwd_sel !== 2'b00) begin bad++; $display("FAIL reset_fwd got=%b exp=00", bus.E_rs1_fwd_sel); end
        tick();
        total++; if (bus.freeze_cnt !== 4'd0) begin bad++; $display("FAIL reset_freeze_cnt got=%0d exp=0", bus.freeze_cnt); end
        do_reset();
        total++; if (ctrl !== 5'b00000) begin bad++; $display("FAIL reset_idle_ctrl got=%b exp=%b", ctrl, 5'b00000); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_d(0, 0, 0, 0, 5, 1, 1);
        tick();
        set_d(5, 1, 1, 1, 6, 1, 0);
        total++; if (ctrl !== 5'b11010) begin bad++; $display("FAIL lu_stall got=%b exp=%b", ctrl, 5'b11010); end
        tick();
        total++; if (ctrl !== 5'b00000) begin bad++; $display("FAIL lu_release got=%b exp=%b", ctrl, 5'b00000); end
        total++; if (bus.stall_cnt !== 4'd1) begin bad++; $display("FAIL lu_stall_cnt got=%0d exp=1", bus.stall_cnt); end
        tick();
        set_d(0, 0, 0, 0, 0, 0, 0);
        total++; if (bus.E_rs1_fwd_sel !== 2'b10) begin bad++; $display("FAIL lu_fwd_rs1 got=%b exp=10", bus.E_rs1_fwd_sel); end
        total++; if (bus.E_rs2_fwd_sel !== 2'b00) begin bad++; $display("FAIL lu_fwd_rs2 got=%b exp=00", bus.E_rs2_fwd_sel); end
    endtask

    task automatic test_forwarding();
        do_reset();
        set_d(0, 0, 0, 0, 3, 1, 0); tick();
        set_d(0, 0, 0, 0, 3, 1, 0); tick();
        set_d(3, 0, 1, 1, 7, 1, 0); tick();
        total++; if (bus.E_rs1_fwd_sel !== 2'b01) begin bad++; $display("FAIL fwd_m_over_w got=%b exp=01", bus.E_rs1_fwd_sel); end
        set_d(0, 0, 0, 0, 0, 1, 0); tick();
        set_d(0, 0, 0, 0, 0, 1, 0); tick();
        set_d(0, 0, 1, 1, 8, 1, 0); tick();
        total++; if (bus.E_rs1_fwd_sel !== 2'b00) begin bad++; $display("FAIL fwd_x0 got=%b exp=00", bus.E_rs1_fwd_sel); end
        set_d(0, 0, 0, 0, 9, 1, 0); tick();
        set_d(0, 0, 0, 0, 0, 0, 0); tick();
        set_d(0, 9, 0, 1, 0, 0, 0); tick();
        total++; if (bus.E_rs2_fwd_sel !== 2'b10) begin bad++; $display("FAIL fwd_w_only got=%b exp=10", bus.E_rs2_fwd_sel); end
        set_d(0, 0, 0, 0, 4, 1, 1); tick();
        set_d(4, 0, 0, 0, 0, 0, 0);
        total++; if (ctrl !== 5'b00000) begin bad++; $display("FAIL fwd_unused_no_stall got=%b exp=%b", ctrl, 5'b00000); end
        tick();
        total++; if (bus.E_rs1_fwd_sel !== 2'b00) begin bad++; $display("FAIL fwd_m_load got=%b exp=00", bus.E_rs1_fwd_sel); end
    endtask

    task automatic test_jb_priority();
        do_reset();
        set_d(0, 0, 0, 0, 5, 1, 1); tick();
        bus.E_jb = 1'b1;
        set_d(5, 0, 1, 0, 6, 1, 0);
        total++; if (ctrl !== 5'b00110) begin bad++; $display("FAIL jb_over_lu got=%b exp=%b", ctrl, 5'b00110); end
        tick();
        total++; if (bus.flush_cnt !== 4'd1) begin bad++; $display("FAIL jb_flush_cnt got=%0d exp=1", bus.flush_cnt); end
        total++; if (bus.stall_cnt !== 4'd0) begin bad++; $display("FAIL jb_stall_cnt got=%0d exp=0", bus.stall_cnt); end
        set_d(0, 0, 0, 0, 0, 0, 0);
        total++; if (ctrl !== 5'b00110) begin bad++; $display("FAIL jb_back_to_back got=%b exp=%b", ctrl, 5'b00110); end
        tick();
        bus.E_jb = 1'b0;
        #1;
        total++; if (bus.flush_cnt !== 4'd2) begin bad++; $display("FAIL jb_flush_cnt2 got=%0d exp=2", bus.flush_cnt); end
        total++; if (ctrl !== 5'b00000) begin bad++; $display("FAIL jb_idle got=%b exp=%b", ctrl, 5'b00000); end
    endtask

    task automatic test_freeze();
        do_reset();
        bus.E_jb = 1'b1;
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (ctrl !== 5'b11001) begin bad++; $display("FAIL frz_cycle%0d got=%b exp=%b", i, ctrl, 5'b11001); end
            tick();
        end
        bus.mem_busy = 1'b0;
        #1;
        total++; if (ctrl !== 5'b00110) begin bad++; $display("FAIL frz_then_flush got=%b exp=%b", ctrl, 5'b00110); end
        tick();
        bus.E_jb = 1'b0;
        #1;
        total++; if (bus.freeze_cnt !== 4'd3) begin bad++; $display("FAIL frz_cnt got=%0d exp=3", bus.freeze_cnt); end
        total++; if (bus.flush_cnt !== 4'd1) begin bad++; $display("FAIL frz_flush_cnt got=%0d exp=1", bus.flush_cnt); end
    endtask

    task automatic test_freeze_hold();
        do_reset();
        set_d(0, 0, 0, 0, 5, 1, 1); tick();
        set_d(0, 5, 0, 1, 6, 1, 0);
        bus.mem_busy = 1'b1;
        #1;
        total++; if (ctrl !== 5'b11001) begin bad++; $display("FAIL hold_frz got=%b exp=%b", ctrl, 5'b11001); end
        tick(); tick();
        bus.mem_busy = 1'b0;
        #1;
        total++; if (ctrl !== 5'b11010) begin bad++; $display("FAIL hold_lu_after got=%b exp=%b", ctrl, 5'b11010); end
        tick();
        total++; if (bus.stall_cnt !== 4'd1) begin bad++; $display("FAIL hold_stall_cnt got=%0d exp=1", bus.stall_cnt); end
        total++; if (bus.freeze_cnt !== 4'd2) begin bad++; $display("FAIL hold_freeze_cnt got=%0d exp=2", bus.freeze_cnt); end
    endtask

    task automatic test_sat_reset();
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            set_d(0, 0, 0, 0, 5, 1, 1); tick();
            set_d(5, 0, 1, 0, 6, 1, 0); tick();
            if (i >= 15) begin
                total++; if (bus.stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_stall%0d got=%0d exp=15", i, bus.stall_cnt); end
            end
        end
        set_d(0, 0, 0, 0, 5, 1, 1); tick();
        bus.mem_busy = 1'b1;
        set_d(5, 0, 1, 0, 6, 1, 0); tick();
        rst = 1'b1;
        bus.E_jb = 1'b1;
        #1;
        total++; if (ctrl !== 5'b00000) begin bad++; $display("FAIL rst_frz_ctrl got=%b exp=%b", ctrl, 5'b00000); end
        total++; if (bus.stall_cnt !== 4'd0) begin bad++; $display("FAIL rst_frz_cnt got=%0d exp=0", bus.stall_cnt); end
        tick();
        rst = 1'b0;
        bus.E_jb = 1'b0;
        bus.mem_busy = 1'b0;
        #1;
        total++; if (ctrl !== 5'b00000) begin bad++; $display("FAIL rst_after_ctrl got=%b exp=%b", ctrl, 5'b00000); end
        total++; if (bus.freeze_cnt !== 4'd0) begin bad++; $display("FAIL rst_after_frz_cnt got=%0d exp=0", bus.freeze_cnt); end
        total++; if (bus.stall_cnt !== 4'd0) begin bad++; $display("FAIL rst_after_stall_cnt got=%0d exp=0", bus.stall_cnt); end
    endtask

    initial begin
        bus.E_jb = 1'b0;
        bus.mem_busy = 1'b0;
        set_d(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_load_use();
        test_forwarding();
        test_jb_priority();
        test_freeze();
        test_freeze_hold();
        test_sat_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
